// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared types, phase codes and dwell range check for mux_sel_sequencer
package mux_seq_pkg;
  typedef enum logic [1:0] {IDLE, SEL, TGL} state_t;
  typedef logic [1:0] sel_code_t;
  localparam logic [2:0] PH_IDLE = 3'd7;
  localparam logic [2:0] PH_TGL = 3'd4;
  function automatic bit dwell_ok(input int d, input int w);
    return d >= 1 && d < (1 << w);
  endfunction
endpackage

// File: rtl/mux_sel_sequencer_dwell_counter.sv
// dwell_counter: CNT_W down-counter; last is high on the final cycle of a dwell
//   clk, rst        clock, synchronous active-high reset
//   load, load_val  start a new dwell of load_val cycles
//   hold            freeze the count
//   last            count == 1
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             last
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (!hold && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign last = r_cnt == CNT_W'(1);
endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: steps MUX_2 S through 00..11 with programmable dwells, then inverts EN
//   clk, rst        clock, synchronous active-high reset
//   start, stop     start request (ignored while busy), abort request (wins over start)
//   loop            restart at phase 0 after the EN toggle instead of finishing
//   pause           only with SEQ_PAUSE_EN: freezes a running sequence
//   sel_s, sel_en   to MUX_2 S and EN
//   busy, done      sequence running, one-cycle pulse at the end of a non-looping pass
//   phase           0-3 select phases, 4 toggle phase, 7 idle
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DWELL0   = 3,
  parameter int DWELL1   = 5,
  parameter int DWELL2   = 7,
  parameter int DWELL3   = 11,
  parameter int DWELL_EN = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
`ifdef SEQ_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       loop,
  output sel_code_t  sel_s,
  output logic       sel_en,
  output logic       busy,
  output logic       done,
  output logic [2:0] phase
);
  if (!(dwell_ok(DWELL0, CNT_W) && dwell_ok(DWELL1, CNT_W) && dwell_ok(DWELL2, CNT_W) &&
        dwell_ok(DWELL3, CNT_W) && dwell_ok(DWELL_EN, CNT_W))) begin : g_bad_dwell
    $error("mux_sel_sequencer: every dwell must be in 1..2**CNT_W-1");
  end
  state_t           r_state, w_state;
  sel_code_t        r_sel, w_sel;
  logic             r_en, w_en, r_done, w_done;
  logic             w_hold, w_last, w_load;
  logic [CNT_W-1:0] w_load_val;
`ifdef SEQ_PAUSE_EN
  assign w_hold = pause && r_state != IDLE;
`else
  assign w_hold = 1'b0;
`endif
  dwell_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .load_val(w_load_val),
    .hold    (w_hold),
    .last    (w_last)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_en    <= w_en;
      r_done  <= w_done;
    end
  // Every phase change reloads the counter; the TGL exit reloads DWELL0 whether or not it loops.
  always_comb begin
    w_state    = r_state;
    w_sel      = r_sel;
    w_en       = r_en;
    w_done     = 1'b0;
    w_load     = 1'b0;
    w_load_val = CNT_W'(DWELL0);
    if (r_state == IDLE) begin
      if (start && !stop) begin
        w_state = SEL;
        w_sel   = 2'd0;
        w_load  = 1'b1;
      end
    end else if (stop) begin
      w_state = IDLE;
      w_sel   = 2'd0;
    end else if (!w_hold && w_last) begin
      w_load = 1'b1;
      if (r_state == TGL) begin
        w_en    = !r_en;
        w_sel   = 2'd0;
        w_state = loop ? SEL : IDLE;
        w_done  = !loop;
      end else if (r_sel == 2'd3) begin
        w_state    = TGL;
        w_load_val = CNT_W'(DWELL_EN);
      end else begin
        w_sel      = r_sel + 2'd1;
        w_load_val = r_sel == 2'd0 ? CNT_W'(DWELL1) : r_sel == 2'd1 ? CNT_W'(DWELL2) : CNT_W'(DWELL3);
      end
    end
  end
  always_comb begin
    sel_s  = r_sel;
    sel_en = r_en;
    busy   = r_state != IDLE;
    done   = r_done;
    phase  = r_state == IDLE ? PH_IDLE : r_state == TGL ? PH_TGL : {1'b0, r_sel};
  end
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: vector table, directed corner sequences and random run against a pass-position model
module tb_mux_sel_sequencer;
  localparam int D [5] = '{3, 5, 7, 11, 13};
  localparam int TOT = 39;
  typedef struct {
    logic r, s, p, l;
    logic [1:0] sel;
    logic en, busy, done;
    logic [2:0] ph;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0, pause = 1'b0;
  logic [1:0] sel_s;
  logic sel_en, busy, done;
  logic [2:0] phase;
  int total = 0, bad = 0;
  bit m_busy = 1'b0, m_en = 1'b0, m_done = 1'b0;
  int m_pos = 0;
  always #5 clk = ~clk;
  mux_sel_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
`ifdef SEQ_PAUSE_EN
    .pause (pause),
`endif
    .loop  (loop),
    .sel_s (sel_s),
    .sel_en(sel_en),
    .busy  (busy),
    .done  (done),
    .phase (phase)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int exp_sel();
    int acc = 0;
    if (!m_busy) return 0;
    for (int k = 0; k < 4; k++) begin
      acc += D[k];
      if (m_pos < acc) return k;
    end
    return 3;
  endfunction
  function automatic int exp_phase();
    if (!m_busy) return 7;
    return m_pos >= TOT - D[4] ? 4 : exp_sel();
  endfunction
  task automatic model_step();
    bit p;
`ifdef SEQ_PAUSE_EN
    p = pause;
`else
    p = 1'b0;
`endif
    if (rst) begin
      m_busy = 0; m_pos = 0; m_en = 0; m_done = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (start && !stop) begin m_busy = 1; m_pos = 0; end
    end else if (stop) begin
      m_busy = 0; m_done = 0;
    end else if (!p) begin
      m_pos++;
      if (m_pos == TOT) begin
        m_en = !m_en; m_pos = 0;
        if (!loop) begin m_busy = 0; m_done = 1; end
      end
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("sel_s", sel_s, exp_sel());
    chk("sel_en", sel_en, m_en);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("phase", phase, exp_phase());
  endtask
  task automatic do_reset();
    rst = 1; start = 0; stop = 0; loop = 0; pause = 0;
    tick(); tick();
    rst = 0;
  endtask
  task automatic launch(output int t);
    start = 1; tick(); start = 0; t = 0;
  endtask
  vec_t tbl [10];
  initial begin
    int t, ntog, n [4];
    logic pe, en_before;
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 7};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 7};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 7};
    tbl[3] = '{0, 1, 1, 0, 0, 0, 0, 0, 7};
    tbl[4] = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 1, 0, 1, 0, 1};
    tbl[8] = '{0, 0, 1, 0, 0, 0, 0, 0, 7};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 7};
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].r; start = tbl[i].s; stop = tbl[i].p; loop = tbl[i].l;
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_sel", i), sel_s, tbl[i].sel);
      chk($sformatf("vec%0d_en", i), sel_en, tbl[i].en);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_done", i), done, tbl[i].done);
      chk($sformatf("vec%0d_phase", i), phase, tbl[i].ph);
    end
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    chk("idle_busy", busy, 0);
    chk("idle_phase", phase, 7);
    n = '{0, 0, 0, 0};
    launch(t);
    n[sel_s]++;
    for (int i = 0; i < 60; i++) begin
      start = t == 4;
      tick();
      t++;
      if (!busy) break;
      n[sel_s]++;
    end
    start = 0;
    chk("pass_len", t, TOT);
    chk("pass_done", done, 1);
    chk("pass_en", sel_en, 1);
    chk("cnt_00", n[0], 3);
    chk("cnt_01", n[1], 5);
    chk("cnt_10", n[2], 7);
    chk("cnt_11", n[3], 24);
    tick();
    chk("done_once", done, 0);
    en_before = sel_en;
    launch(t);
    while (t < 10) begin tick(); t++; end
    chk("stop_pre_sel", sel_s, 2);
    stop = 1; tick(); stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_sel", sel_s, 0);
    chk("stop_done", done, 0);
    chk("stop_en", sel_en, en_before);
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("start_stop_idle", busy, 0);
    launch(t);
    while (t < 30) begin tick(); t++; end
    chk("tgl_phase", phase, 4);
    rst = 1; tick(); rst = 0;
    chk("rst_tgl_en", sel_en, 0);
    chk("rst_tgl_busy", busy, 0);
    chk("rst_tgl_phase", phase, 7);
    do_reset();
    loop = 1;
    ntog = 0;
    launch(t);
    pe = sel_en;
    while (t < 80) begin
      tick(); t++;
      if (sel_en !== pe) begin
        ntog++;
        chk($sformatf("loop_tog%0d_t", ntog), t, ntog * TOT);
        chk("loop_tog_sel", sel_s, 0);
        chk("loop_tog_busy", busy, 1);
        chk("loop_tog_done", done, 0);
        pe = sel_en;
      end
    end
    chk("loop_tog_count", ntog, 2);
    stop = 1; tick(); stop = 0;
    do_reset();
    loop = 1;
    launch(t);
    for (int i = 0; i < 120; i++) begin
      loop = t < 50;
      tick(); t++;
      if (done) break;
    end
    chk("loop_end_t", t, 2 * TOT);
    chk("loop_end_en", sel_en, 0);
`ifdef SEQ_PAUSE_EN
    do_reset();
    n = '{0, 0, 0, 0};
    launch(t);
    n[sel_s]++;
    for (int i = 0; i < 80; i++) begin
      pause = t >= 4 && t < 8;
      tick(); t++;
      if (!busy) break;
      n[sel_s]++;
    end
    pause = 0;
    chk("pause_len", t, TOT + 4);
    chk("pause_01", n[1], 9);
`endif
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(199) == 0;
      start = $urandom_range(7) == 0;
      stop = $urandom_range(59) == 0;
      loop = $urandom_range(2) != 0;
`ifdef SEQ_PAUSE_EN
      pause = $urandom_range(9) == 0;
`endif
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
